// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads have strict priority over host
// accesses; a return tag routes each read's data to its owner one cycle later.
module vga_fb_arbiter #(
   parameter int AW           = 16,
   parameter int DW           = 12,
   parameter int STARVE_LIMIT = 255
) (
   input  logic          clk12,
   input  logic          reset,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic          disp_grant,
   output logic [DW-1:0] disp_rdata,
   output logic          disp_rvalid,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   output logic          host_rvalid,
   output logic          host_starved,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam int CW_MIN = $clog2(STARVE_LIMIT + 1);
   localparam int CW     = (CW_MIN > 9) ? CW_MIN : 9;
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST} tag_t;

   tag_t          tag, tag_nxt;
   logic [CW-1:0] wait_cnt;
   logic [DW-1:0] disp_hold, host_hold;

   // Grants are purely combinational; reset masks them so nothing reaches the RAM.
   always_comb begin
      disp_grant = 1'b0;
      host_ack   = 1'b0;
      ram_en     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_wdata  = '0;
      tag_nxt    = TAG_NONE;
      if (!reset) begin
         disp_grant = disp_req;
         host_ack   = host_req & ~disp_req;
         if (disp_req) begin
            ram_en   = 1'b1;
            ram_addr = disp_addr;
            tag_nxt  = TAG_DISP;
         end else if (host_req) begin
            ram_en   = 1'b1;
            ram_addr = host_addr;
            if (host_we) begin
               ram_we    = 1'b1;
               ram_wdata = host_wdata;
            end else begin
               tag_nxt = TAG_HOST;
            end
         end
      end
   end

   always_ff @(posedge clk12 or posedge reset) begin
      if (reset) begin
         tag       <= TAG_NONE;
         disp_hold <= '0;
         host_hold <= '0;
         wait_cnt  <= '0;
      end else begin
         tag <= tag_nxt;
         if (tag == TAG_DISP) disp_hold <= ram_rdata;
         if (tag == TAG_HOST) host_hold <= ram_rdata;
         if (host_req && !host_ack) begin
            if (wait_cnt < LIMIT) wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   // Live RAM data in the return cycle keeps latency at one; holds cover idle cycles.
   assign disp_rvalid  = (tag == TAG_DISP);
   assign host_rvalid  = (tag == TAG_HOST);
   assign disp_rdata   = disp_rvalid ? ram_rdata : disp_hold;
   assign host_rdata   = host_rvalid ? ram_rdata : host_hold;
   assign host_starved = (wait_cnt >= LIMIT);

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with hand-computed expectations.
module tb_vga_fb_arbiter;
   logic        clk12 = 1'b0;
   logic        reset;
   logic        disp_req, host_req, host_we;
   logic [15:0] disp_addr, host_addr, ram_addr;
   logic [11:0] host_wdata, ram_rdata, ram_wdata, disp_rdata, host_rdata;
   logic        disp_grant, disp_rvalid, host_ack, host_rvalid, host_starved;
   logic        ram_en, ram_we;

   int n_cmp = 0;
   int n_bad = 0;

   vga_fb_arbiter dut (
      .clk12(clk12), .reset(reset),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_grant(disp_grant),
      .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
      .host_rvalid(host_rvalid), .host_starved(host_starved),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk12 = ~clk12;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk12);
      #1;
   endtask

   initial begin
      reset = 1'b1; disp_req = 1'b1; disp_addr = 16'h0044; host_req = 1'b0;
      host_we = 1'b0; host_addr = '0; host_wdata = '0; ram_rdata = '0;
      step(); #2;
      chk("rst_disp_grant", disp_grant, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_disp_rvalid", disp_rvalid, 0);
      chk("rst_disp_rdata", disp_rdata, 0);
      chk("rst_starved", host_starved, 0);
      disp_req = 1'b0;
      step();
      reset = 1'b0;

      // display read
      disp_req = 1'b1; disp_addr = 16'h0010; #2;
      chk("dr_grant", disp_grant, 1);
      chk("dr_ram_en", ram_en, 1);
      chk("dr_ram_addr", ram_addr, 16'h0010);
      chk("dr_host_ack", host_ack, 0);
      step();
      disp_req = 1'b0; ram_rdata = 12'hABC; #2;
      chk("dr_rvalid", disp_rvalid, 1);
      chk("dr_rdata", disp_rdata, 12'hABC);
      chk("dr_host_rvalid", host_rvalid, 0);
      chk("idle_ram_en", ram_en, 0);
      step();
      ram_rdata = 12'h555; #2;
      chk("dr_rvalid_off", disp_rvalid, 0);
      chk("dr_rdata_hold", disp_rdata, 12'hABC);

      // collision: display wins, host write goes next cycle
      disp_req = 1'b1; disp_addr = 16'h0030;
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wdata = 12'h123; #2;
      chk("col_disp_grant", disp_grant, 1);
      chk("col_host_ack", host_ack, 0);
      chk("col_ram_we", ram_we, 0);
      chk("col_ram_addr", ram_addr, 16'h0030);
      chk("col_ram_wdata", ram_wdata, 0);
      step();
      disp_req = 1'b0; #2;
      chk("wr_host_ack", host_ack, 1);
      chk("wr_ram_we", ram_we, 1);
      chk("wr_ram_addr", ram_addr, 16'h0020);
      chk("wr_ram_wdata", ram_wdata, 12'h123);
      step();
      host_req = 1'b0; host_we = 1'b0; #2;
      chk("wr_no_host_rvalid", host_rvalid, 0);
      chk("wr_no_ram_we", ram_we, 0);

      // interleaved DISP, HOST, DISP reads
      disp_req = 1'b1; disp_addr = 16'h0001; #2;
      chk("il_grant_a", disp_grant, 1);
      step();
      disp_req = 1'b0; host_req = 1'b1; host_addr = 16'h0002; ram_rdata = 12'h001; #2;
      chk("il_ack_b", host_ack, 1);
      chk("il_ram_addr_b", ram_addr, 16'h0002);
      chk("il_disp_rvalid_a", disp_rvalid, 1);
      chk("il_disp_rdata_a", disp_rdata, 12'h001);
      chk("il_host_rvalid_a", host_rvalid, 0);
      step();
      disp_req = 1'b1; disp_addr = 16'h0003; host_req = 1'b0; ram_rdata = 12'h002; #2;
      chk("il_host_rvalid_b", host_rvalid, 1);
      chk("il_host_rdata_b", host_rdata, 12'h002);
      chk("il_disp_rvalid_b", disp_rvalid, 0);
      step();
      disp_req = 1'b0; ram_rdata = 12'h003; #2;
      chk("il_disp_rvalid_c", disp_rvalid, 1);
      chk("il_disp_rdata_c", disp_rdata, 12'h003);
      chk("il_host_rdata_hold", host_rdata, 12'h002);
      step();

      // starvation: host blocked while display hogs the port
      disp_req = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0077;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (i == 254) chk("sv_not_yet_254", host_starved, 0);
         if (i == 255) chk("sv_rise_255", host_starved, 1);
      end
      chk("sv_held_300", host_starved, 1);
      disp_req = 1'b0; #2;
      chk("sv_ack", host_ack, 1);
      chk("sv_still_starved", host_starved, 1);
      step();
      host_req = 1'b0; ram_rdata = 12'h6A5; #2;
      chk("sv_cleared", host_starved, 0);
      chk("sv_host_rvalid", host_rvalid, 1);
      chk("sv_host_rdata", host_rdata, 12'h6A5);
      step();

      // reset in the cycle a host read is acked
      host_req = 1'b1; host_we = 1'b0; #2;
      chk("rm_ack_pre", host_ack, 1);
      reset = 1'b1; #1;
      chk("rm_ack_forced", host_ack, 0);
      chk("rm_ram_en_forced", ram_en, 0);
      chk("rm_host_rdata_clr", host_rdata, 0);
      chk("rm_disp_rdata_clr", disp_rdata, 0);
      step();
      chk("rm_host_rvalid_rst", host_rvalid, 0);
      chk("rm_starved_rst", host_starved, 0);
      host_req = 1'b0; reset = 1'b0;
      step(); #2;
      chk("rm_host_rvalid_after", host_rvalid, 0);
      chk("rm_disp_rvalid_after", disp_rvalid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 16: word address width.
REQ-002 The block SHALL have parameter DW, default 12: data word width (two 6-bit RRGGBB pixels per word).
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 255: host wait cycles before the starvation flag is raised.
REQ-004 Port clk12  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port disp_req  input  1  scanout read request, held until granted.
REQ-007 Port disp_addr  input  AW  scanout word address.
REQ-008 Port disp_grant  output  1  scanout request accepted this cycle.
REQ-009 Port disp_rdata  output  DW  scanout read data.
REQ-010 Port disp_rvalid  output  1  disp_rdata valid.
REQ-011 Port host_req  input  1  host access request, held with stable fields until host_ack.
REQ-012 Port host_we  input  1  1 = write, 0 = read.
REQ-013 Port host_addr  input  AW  host word address.
REQ-014 Port host_wdata  input  DW  host write data.
REQ-015 Port host_ack  output  1  host request accepted this cycle.
REQ-016 Port host_rdata  output  DW  host read data.
REQ-017 Port host_rvalid  output  1  host_rdata valid.
REQ-018 Port host_starved  output  1  host has waited STARVE_LIMIT cycles or more.
REQ-019 Port ram_en, ram_we  output  1 each  single-port RAM enable and write strobe.
REQ-020 Port ram_addr, ram_wdata  output  AW, DW  RAM address and write data.
REQ-021 Port ram_rdata  input  DW  RAM read data, valid one cycle after a read enable.

Function
REQ-022 Arbitration SHALL be combinational in the request cycle, with strict priority: disp_req wins; host granted only when disp_req=0.
REQ-023 disp_grant SHALL equal disp_req; host_ack SHALL equal host_req AND NOT disp_req.
REQ-024 The granted request SHALL drive ram_en=1, ram_addr and (host write only) ram_we=1 and ram_wdata in the same cycle; with no request, ram_en=0 and ram_we=0.
REQ-025 A return-tag register SHALL record the owner of each read: NONE, DISP or HOST.
  - Tag DISP: next cycle disp_rvalid=1, disp_rdata=ram_rdata.
  - Tag HOST: next cycle host_rvalid=1, host_rdata=ram_rdata.
  - Host writes SHALL set tag NONE and produce no rvalid.
REQ-026 Read latency SHALL be exactly 1 cycle from grant/ack to rvalid; back-to-back reads SHALL return one word per cycle in grant order.
REQ-027 rdata outputs SHALL hold their last value while rvalid=0.
REQ-028 A 9-bit-minimum saturating wait counter SHALL:
  - increment on each cycle host_req=1 and host_ack=0;
  - clear on host_ack or host_req=0;
  - saturate at STARVE_LIMIT.
REQ-029 host_starved SHALL be 1 while the wait counter is at or above STARVE_LIMIT, and SHALL clear in the cycle after host_ack.
REQ-030 Simultaneous disp_req and host_req SHALL grant display, leave the RAM signals unaffected by the host fields, and count one host wait cycle.
REQ-031 Address or data values outside the RAM depth SHALL pass through unmodified; the block SHALL not check range.

Reset
REQ-032 While reset=1, the following SHALL be 0 asynchronously: tag=NONE, disp_rvalid, host_rvalid, host_starved, wait counter, disp_rdata, host_rdata.
REQ-033 A read granted in the cycle reset asserts SHALL produce no rvalid after reset release.
REQ-034 Combinational outputs (grants, RAM controls) SHALL be forced to 0 while reset=1.

Verification
REQ-035 Display read only: disp_req=1, disp_addr=0x0010 for 1 cycle, ram_rdata=0xABC next cycle -> disp_grant=1, ram_en=1, ram_addr=0x0010; next cycle disp_rvalid=1, disp_rdata=0xABC, host_rvalid=0.
REQ-036 Collision: disp_req=1 and host_req=1 (write 0x123 to 0x0020) in the same cycle -> disp granted, host_ack=0, ram_we=0; following cycle with disp_req=0 -> host_ack=1, ram_we=1, ram_addr=0x0020, ram_wdata=0x123.
REQ-037 Interleaved reads DISP, HOST, DISP on consecutive cycles, with ram_rdata 0x001, 0x002, 0x003 -> rvalid pattern disp, host, disp with matching data, one cycle after each grant.
REQ-038 Starvation: disp_req=1 and host_req=1 held for 300 cycles -> host_starved rises at cycle 255 and stays high; drop disp_req -> host_ack=1 that cycle, host_starved=0 the next cycle.
REQ-039 Reset mid-read: host read acked, reset pulsed the same cycle -> host_rvalid stays 0; all registered outputs read 0 during reset.
